// File: rtl/pipe_pkg.sv
// Shared IF/ID definitions: default widths, the decode NOP and the fetch entry layout.
package pipe_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int INS_W_DEF = 32;
    localparam int DEPTH_DEF = 2;

    localparam logic [INS_W_DEF-1:0] NOP_INS_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W_DEF-1:0]  pc;
        logic [INS_W_DEF-1:0] ins;
    } if_id_entry_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Circular buffer with pointers and occupancy; clr empties it at the next edge, rst=0 likewise.
// Read data is the registered head (no bypass); caller must not push when full or pop when empty.
module sync_fifo_core #(
    parameter int  W     = 40,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wr_dat,
    output logic [W-1:0]     rd_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push && pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Storage is never cleared; readers mux the head away whenever empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/pipeir_buf.sv
// Elastic IF/ID buffer: fetch pushes {pc, ins}, decode pops in order; 1-cycle push-to-visible latency.
// in_ready depends only on occupancy (full refuses even with a same-cycle pop); flush beats push/pop.
module pipeir_buf
    import pipe_pkg::*;
#(
    parameter int               PC_W    = PC_W_DEF,
    parameter int               INS_W   = INS_W_DEF,
    parameter int               DEPTH   = DEPTH_DEF,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF),
    localparam int              CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } entry_t;

    entry_t          wr_ent;
    entry_t          rd_ent;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] last_pc_q, last_pc_d;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & ~full & ~flush;
    assign pop       = ~empty & out_ready & ~flush;

    assign wr_ent.pc  = in_pc;
    assign wr_ent.ins = in_ins;

    sync_fifo_core #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .push   (push),
        .pop    (pop),
        .wr_dat (wr_ent),
        .rd_dat (rd_ent),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // While empty, decode keeps seeing the PC it last consumed alongside a NOP.
    always_comb begin
        last_pc_d = last_pc_q;
        if (flush) begin
            last_pc_d = '0;
        end else if (pop) begin
            last_pc_d = rd_ent.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_pc_q <= '0;
        end else begin
            last_pc_q <= last_pc_d;
        end
    end

    assign out_pc  = empty ? last_pc_q : rd_ent.pc;
    assign out_ins = empty ? NOP_INS : rd_ent.ins;

endmodule

// File: tb/tb_pipeir_buf.sv
// Directed and random traffic on pipeir_buf; a queue model predicts every cycle's outputs.
module tb_pipeir_buf;
    import pipe_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pc;
    logic [31:0] in_ins;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_ins;
    logic [1:0]  count;

    pipeir_buf #(
        .PC_W    (8),
        .INS_W   (32),
        .DEPTH   (DEPTH),
        .NOP_INS (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ins    (in_ins),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ins   (out_ins),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of accepted entries plus the last consumed PC.
    if_id_entry_t exp_q[$];
    if_id_entry_t ent;
    logic [7:0]   m_last_pc = 8'h00;
    logic         live = 1'b0;
    logic         m_push;
    logic         m_pop;
    int           n;

    always @(negedge clk) begin
        if (live) begin
            n = exp_q.size();
            check("count", 64'(count), 64'(n));
            check("in_ready", 64'(in_ready), 64'(n != DEPTH));
            check("out_valid", 64'(out_valid), 64'(n != 0));
            if (n != 0) begin
                check("head_pc", 64'(out_pc), 64'(exp_q[0].pc));
                check("head_ins", 64'(out_ins), 64'(exp_q[0].ins));
            end else begin
                check("empty_pc", 64'(out_pc), 64'(m_last_pc));
                check("empty_ins", 64'(out_ins), 64'h0);
            end
        end
        if (!rst || flush) begin
            exp_q.delete();
            m_last_pc = 8'h00;
            if (!rst) live = 1'b1;
        end else if (live) begin
            m_pop  = (exp_q.size() != 0) && out_ready;
            m_push = in_valid && (exp_q.size() != DEPTH);
            if (m_pop) begin
                m_last_pc = exp_q[0].pc;
                void'(exp_q.pop_front());
            end
            if (m_push) begin
                ent.pc  = in_pc;
                ent.ins = in_ins;
                exp_q.push_back(ent);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, input logic rs, output logic acc);
        in_valid  = v;
        in_pc     = pc;
        in_ins    = ins;
        out_ready = rdy;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        acc = v & in_ready & ~fl & rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic        a;
    logic        pend;
    logic        rv, rr, rf, rs;
    logic [7:0]  rpc;
    logic [31:0] rins;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_pc = 8'hAA;
        in_ins = 32'hDEAD_BEEF; out_ready = 1'b1;

        // Reset held two cycles with fetch offering
        step(1'b1, 8'hAA, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 8'hAA, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, a);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ins", 64'(out_ins), 64'h0);
        check("rst_pc", 64'(out_pc), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        step(1'b1, 8'h04, 32'h2001_0005, 1'b0, 1'b0, 1'b1, a);
        check("first_pc", 64'(out_pc), 64'h04);
        check("first_ins", 64'(out_ins), 64'h2001_0005);
        check("first_count", 64'(count), 64'd1);

        // Streaming: one in, one out each cycle
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(i * 4), 32'h1000_0000 + i, 1'b1, 1'b0, 1'b1, a);
            check("stream_pc", 64'(out_pc), 64'(i * 4));
            check("stream_count", 64'(count), 64'd1);
        end
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, a);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_last_pc", 64'(out_pc), 64'h0C);
        check("drain_nop", 64'(out_ins), 64'h0);

        // Stall until full, then one pop frees a slot only for the following cycle
        step(1'b1, 8'h10, 32'h1111_0010, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 8'h14, 32'h1111_0014, 1'b0, 1'b0, 1'b1, a);
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 8'h18, 32'h1111_0018, 1'b0, 1'b0, 1'b1, a);
        check("full_refused", 64'(a), 64'd0);
        check("stall_pc", 64'(out_pc), 64'h10);
        step(1'b1, 8'h18, 32'h1111_0018, 1'b1, 1'b0, 1'b1, a);
        check("full_pop_refused", 64'(a), 64'd0);
        check("after_pop_pc", 64'(out_pc), 64'h14);
        check("after_pop_count", 64'(count), 64'd1);
        step(1'b1, 8'h18, 32'h1111_0018, 1'b0, 1'b0, 1'b1, a);
        check("held_accepted", 64'(a), 64'd1);
        check("held_count", 64'(count), 64'd2);

        // Flush with push and pop both requested
        step(1'b1, 8'h1C, 32'h1111_001C, 1'b1, 1'b1, 1'b1, a);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ins", 64'(out_ins), 64'h0);
        check("flush_pc", 64'(out_pc), 64'h0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, a);

        // Reset and flush together mid-stream, then resume
        step(1'b1, 8'h20, 32'h2222_0020, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 8'h24, 32'h2222_0024, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 8'h28, 32'h2222_0028, 1'b1, 1'b1, 1'b0, a);
        check("rstfl_count", 64'(count), 64'd0);
        check("rstfl_pc", 64'(out_pc), 64'h0);
        step(1'b1, 8'h30, 32'h3333_0030, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 8'h34, 32'h3333_0034, 1'b0, 1'b0, 1'b1, a);
        check("resume_count", 64'(count), 64'd2);
        check("resume_pc", 64'(out_pc), 64'h30);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, a);
        check("resume_next_pc", 64'(out_pc), 64'h34);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, a);

        // Random traffic; fetch holds an offer until it is taken, flushed or reset
        pend = 1'b0;
        rv = 1'b0; rpc = 8'h00; rins = 32'h0;
        for (int i = 0; i < 800; i++) begin
            if (!pend) begin
                rv   = ($urandom_range(0, 3) != 0);
                rpc  = 8'($urandom);
                rins = $urandom;
            end
            rr = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 99) != 0);
            step(rv, rpc, rins, rr, rf, rs, a);
            pend = rv && !a && !rf && rs;
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, a);
        end
        check("final_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeir_buf.md
Name: pipeir_buf

Overview:
- Parametrised IF/ID stage successor: a DEPTH-entry elastic instruction buffer between fetch and decode.
- Replaces the single hold-enable register with a valid/ready handshake on both sides, synchronous flush for branch/jump redirect, NOP injection while empty, and an occupancy output.
- Fetch pushes {pc, instruction}; decode pops in order.

Parameters:
- PC_W, 8, PC width in bits.
- INS_W, 32, instruction width in bits.
- DEPTH, 2, buffer entries; power of two, ≥2.
- NOP_INS, 32'h0000_0000, instruction presented to decode when empty (INS_W bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  buffer can accept this cycle.
- in_pc  in  PC_W  PC of offered instruction.
- in_ins  in  INS_W  offered instruction.
- flush  in  1  discard all contents (redirect).
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes head this cycle (0 = stall, old wpcir=0).
- out_pc  out  PC_W  head PC.
- out_ins  out  INS_W  head instruction, or NOP_INS when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular array, rd_ptr and wr_ptr of $clog2(DEPTH) bits, plus count. Pointers wrap modulo DEPTH naturally.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It depends only on state, with no combinational path from out_ready, so a full buffer refuses a push even when a same-cycle pop occurs.
- out_valid = (count != 0).
- out_pc = mem[rd_ptr].pc when count != 0, else last_pc (PC of the most recently popped entry; 0 after reset or flush).
- out_ins = mem[rd_ptr].ins when count != 0, else NOP_INS.
- Latency: an entry pushed at edge N is visible on out_* after edge N; there is no same-cycle bypass from in_* to out_*. Minimum fetch-to-decode latency is 1 cycle, matching the old register.
- push only: mem[wr_ptr] <= {in_pc, in_ins}; wr_ptr++; count++.
- pop only: last_pc <= out_pc; rd_ptr++; count--.
- push & pop: both pointers advance; count unchanged. This is legal at any count from 1 to DEPTH-1, and at count 0 push only.
- out_ready while empty: no effect.
- flush=1: at the next edge rd_ptr=wr_ptr=0, count=0, last_pc=0.
  - The same-cycle in_valid is dropped, not stored.
  - The same-cycle pop is ignored; last_pc is not updated.
  - Flush has priority over push and pop.
- rst=0: same as flush. Additionally, reset takes priority over flush. Storage contents need not be cleared.
- Reset mid-operation discards entries; outputs show out_valid=0, out_pc=0, out_ins=NOP_INS from the first edge where rst=0 is sampled.
- When rst returns to 1, the first push is accepted on that same edge's following cycle as normal.
- Stall (out_ready=0) holds out_pc/out_ins stable while fetch continues filling up to DEPTH. Once full, in_ready=0 and fetch must hold its PC.
- No X on outputs after reset, even though storage is uninitialised; empty outputs are muxed to NOP_INS/last_pc.

Decomposition:
- Shared package pipe_pkg: PC_W, INS_W defaults, NOP_INS constant, if_id_entry_t struct {pc, ins}.
- One natural sub-module: sync_fifo_core (storage array, pointers, count, full/empty; no flush priority logic). pipeir_buf wraps it with flush/reset priority, NOP/last_pc output muxing and handshake gating.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 → out_valid=0, out_ins=32'h0, out_pc=0, count=0, in_ready=1; after release, push pc=8'h04, ins=32'h2001_0005 → next cycle out_pc=04, out_ins=2001_0005, count=1.
- Streaming: out_ready=1, push pc 00, 04, 08, 0C on consecutive cycles → decode sees the same sequence one cycle later, count stays 1, no bubbles.
- Stall/full (DEPTH=2): out_ready=0, push pc 10, 14, 18 → 10 and 14 accepted, in_ready=0 at count=2, 18 held by fetch; out_pc stays 10. Raise out_ready for one cycle → 10 popped, 18 accepted next cycle.
- Flush priority: count=2 with in_valid=1, out_ready=1 and flush=1 → next cycle count=0, out_valid=0, out_ins=NOP_INS, out_pc=0; flushed and incoming entries never appear.
- Wrap-around: DEPTH=4, 10 push/pop pairs with varying stalls → in-order delivery across pointer wrap; count never exceeds 4; scoreboard matches.
- Reset vs flush: rst=0 and flush=1 together mid-stream → reset state. Then rst=1, flush=0 and push 2 entries → normal delivery resumes.
